rmii_packet_rx: RTL and testbench

- RMII receive path, the counterpart of packet_tx. Takes the PHY dibit stream (crs_dv, rxd[1:0], rx_er) and strips the preamble and SFD.
- Reassembles bytes LSB-dibit-first and presents each frame as a byte-wide AXI-Stream master.
- Frame bytes include the FCS. The FCS is checked, and any error is reported on m_axis_tuser on the last beat.
- Sits between the RMII pins and the MAC/packet-filter logic, on the same 50 MHz clock as the transmitter.

---
 rtl/rmii_packet_rx.sv | 206 ++++++++++++++++++++
 tb/tb_rmii_packet_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rmii_packet_rx.sv
// RMII receive path: strips preamble/SFD, packs dibits into bytes, checks FCS and
// length, and presents each frame on a byte-wide AXI-Stream master through a FIFO.
module rmii_packet_rx #(
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned MIN_BYTES  = 64,
  parameter bit          CHECK_FCS  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crs_dv,
  input  logic [1:0] rxd,
  input  logic       rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  input  logic       m_axis_tready,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W   = PTR_W + 1;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned ENTRY_W = 10;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_e;

  state_e               state_q, state_d;
  logic [1:0]           dibit_cnt_q, dibit_cnt_d;
  logic [7:0]           byte_q, byte_d;
  logic [31:0]          crc_q, crc_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic                 rxer_q, rxer_d;
  logic                 ovf_q, ovf_d;
  logic                 held_valid_q, held_valid_d;
  logic [7:0]           held_byte_q, held_byte_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]     count_q, count_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];

  logic                 byte_done_c, frame_end_c, bad_c;
  logic [7:0]           byte_next_c;
  logic                 push_c, pop_c;
  logic [ENTRY_W-1:0]   push_entry_c, head_c;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (crs_dv && rxd == 2'b01) state_d = S_PREAMBLE;
      S_PREAMBLE: begin
        if (!crs_dv)              state_d = S_IDLE;
        else if (rxd == 2'b11)    state_d = S_DATA;
        else if (rxd != 2'b01)    state_d = S_DROP;
      end
      S_DATA:     if (!crs_dv) state_d = S_IDLE;
      S_DROP:     if (!crs_dv) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // FSM-decoded controls
  always_comb begin
    byte_done_c = 1'b0;
    frame_end_c = 1'b0;
    if (state_q == S_DATA) begin
      byte_done_c = crs_dv && (dibit_cnt_q == 2'd3);
      frame_end_c = !crs_dv;
    end
  end

  assign byte_next_c = {rxd, byte_q[7:2]};
  assign pop_c       = m_axis_tvalid && m_axis_tready;
  assign bad_c       = rxer_q || (dibit_cnt_q != 2'd0) || (byte_cnt_q < CNT_W'(MIN_BYTES)) ||
                       (CHECK_FCS && (crc_q != CRC_RESIDUE)) || ovf_q;

  // Byte assembly, hold-back register and frame status
  always_comb begin
    dibit_cnt_d  = dibit_cnt_q;
    byte_d       = byte_q;
    crc_d        = crc_q;
    byte_cnt_d   = byte_cnt_q;
    rxer_d       = rxer_q;
    ovf_d        = ovf_q;
    held_valid_d = held_valid_q;
    held_byte_d  = held_byte_q;
    ok_d         = 1'b0;
    err_d        = 1'b0;
    push_c       = 1'b0;
    push_entry_c = '0;
    if (state_q == S_DATA && crs_dv) begin
      dibit_cnt_d = dibit_cnt_q + 2'd1;
      byte_d      = byte_next_c;
      if (rx_er) rxer_d = 1'b1;
      if (byte_done_c) begin
        crc_d        = crc_byte(crc_q, byte_next_c);
        if (byte_cnt_q != {CNT_W{1'b1}}) byte_cnt_d = byte_cnt_q + CNT_W'(1);
        held_byte_d  = byte_next_c;
        held_valid_d = 1'b1;
        if (held_valid_q) begin
          // Keep one slot free so the closing beat always has room
          if (count_q < OCC_W'(FIFO_DEPTH - 1)) begin
            push_c       = 1'b1;
            push_entry_c = {1'b0, 1'b0, held_byte_q};
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
    end else begin
      if (frame_end_c && held_valid_q) begin
        if (count_q < OCC_W'(FIFO_DEPTH) || pop_c) begin
          push_c       = 1'b1;
          push_entry_c = {bad_c, 1'b1, held_byte_q};
          ok_d         = !bad_c;
          err_d        = bad_c;
        end else begin
          err_d = 1'b1;
        end
      end
      dibit_cnt_d  = 2'd0;
      byte_d       = 8'h00;
      crc_d        = 32'hFFFF_FFFF;
      byte_cnt_d   = '0;
      rxer_d       = 1'b0;
      ovf_d        = 1'b0;
      held_valid_d = 1'b0;
      held_byte_d  = 8'h00;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dibit_cnt_q  <= 2'd0;
      byte_q       <= 8'h00;
      crc_q        <= 32'hFFFF_FFFF;
      byte_cnt_q   <= '0;
      rxer_q       <= 1'b0;
      ovf_q        <= 1'b0;
      held_valid_q <= 1'b0;
      held_byte_q  <= 8'h00;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      dibit_cnt_q  <= dibit_cnt_d;
      byte_q       <= byte_d;
      crc_q        <= crc_d;
      byte_cnt_q   <= byte_cnt_d;
      rxer_q       <= rxer_d;
      ovf_q        <= ovf_d;
      held_valid_q <= held_valid_d;
      held_byte_q  <= held_byte_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      count_q      <= count_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO storage; contents are qualified by count so need no reset
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= push_entry_c;
  end

  assign head_c        = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head_c[7:0] : 8'h00;
  assign m_axis_tlast  = m_axis_tvalid && head_c[8];
  assign m_axis_tuser  = m_axis_tvalid && head_c[9];
  assign frame_ok      = ok_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_rmii_packet_rx.sv
// Bench for rmii_packet_rx: frame table driven through an RMII dibit driver,
// beats checked against a scoreboard queue filled from a reference frame model.
module tb_rmii_packet_rx;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       crs_dv;
  logic [1:0] rxd;
  logic       rx_er;
  logic [7:0] tdata;
  logic       tvalid, tlast, tuser, tready;
  logic       frame_ok, frame_err;

  always #10 clk = ~clk;

  rmii_packet_rx #(.FIFO_DEPTH(DEPTH), .MIN_BYTES(64), .CHECK_FCS(1'b1)) dut (
    .clk(clk), .rst(rst), .crs_dv(crs_dv), .rxd(rxd), .rx_er(rx_er),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
    .m_axis_tuser(tuser), .m_axis_tready(tready),
    .frame_ok(frame_ok), .frame_err(frame_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  typedef struct {
    int len;        // payload bytes before FCS
    int flip_idx;   // byte whose bit 0 is flipped after FCS, -1 none
    int er_idx;     // byte sent with rx_er high, -1 none
    bit extra;      // trailing odd dibit
    bit bad_pre;    // preamble carries rxd=10
    bit hold;       // tready low for the whole frame
    bit exp_ok;
    bit exp_err;
    int exp_beats;
  } vec_t;

  vec_t  vecs[9];
  beat_t sb[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    beats_seen = 0;
  int    ok_seen = 0;
  int    err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic dv, input logic [1:0] d, input logic er);
    @(posedge clk); #1;
    crs_dv = dv; rxd = d; rx_er = er;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic er);
    for (int i = 0; i < 4; i++) drive(1'b1, b[2*i +: 2], er);
  endtask

  task automatic monitor_step();
    beat_t e;
    if (!rst) begin
      if (frame_ok)  ok_seen++;
      if (frame_err) err_seen++;
      if (frame_ok || frame_err) check("pulse_exclusive", {31'h0, frame_ok && frame_err}, 32'h0);
      if (tvalid && tready) begin
        beats_seen++;
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_beat: got data=%0h last=%0b user=%0b expected none", tdata, tlast, tuser);
        end else begin
          e = sb.pop_front();
          check("beat", {22'h0, tdata, tlast, tuser}, {22'h0, e.data, e.last, e.user});
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0]  fr[$];
    logic [31:0] crc;
    beat_t       b;
    int          n, s_beats, s_ok, s_err;
    fr = {};
    for (int i = 0; i < v.len; i++) fr.push_back(8'(i));
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < v.len; i++) begin
      crc = crc ^ {24'h0, fr[i]};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    for (int k = 0; k < 4; k++) fr.push_back(crc[8*k +: 8]);
    if (v.flip_idx >= 0) fr[v.flip_idx] = fr[v.flip_idx] ^ 8'h01;
    n = fr.size();
    if (!v.bad_pre) begin
      for (int i = 0; i < n; i++) begin
        if (v.hold && i >= int'(DEPTH) - 1 && i != n - 1) continue;
        b.data = fr[i];
        b.last = (i == n - 1);
        b.user = (i == n - 1) ? v.exp_err : 1'b0;
        sb.push_back(b);
      end
    end
    s_beats = beats_seen; s_ok = ok_seen; s_err = err_seen;
    tready = !v.hold;
    for (int p = 0; p < 7; p++) begin
      if (v.bad_pre && p == 2) begin
        drive(1'b1, 2'b01, 1'b0); drive(1'b1, 2'b10, 1'b0);
        drive(1'b1, 2'b01, 1'b0); drive(1'b1, 2'b01, 1'b0);
      end else begin
        send_byte(8'h55, 1'b0);
      end
    end
    send_byte(8'hD5, 1'b0);
    for (int i = 0; i < n; i++) send_byte(fr[i], (i == v.er_idx));
    if (v.extra) drive(1'b1, 2'b01, 1'b0);
    if (v.hold) begin
      @(negedge clk);
      check({tag, "_stall_head"}, {23'h0, tvalid, tdata}, {23'h0, 1'b1, fr[0]});
    end
    drive(1'b0, 2'b00, 1'b0);
    tready = 1'b1;
    if (!v.bad_pre) begin
      @(posedge clk); @(negedge clk);
      check({tag, "_end_pulse"}, {30'h0, frame_ok, frame_err}, {30'h0, v.exp_ok, v.exp_err});
      if (!v.hold) check({tag, "_last_latency"}, {30'h0, tvalid, tlast}, 32'h3);
    end
    repeat (12) drive(1'b0, 2'b00, 1'b0);
    for (int c = 0; c < 400 && sb.size() != 0; c++) @(posedge clk);
    check({tag, "_drain"}, sb.size(), 0);
    sb = {};
    repeat (4) @(posedge clk);
    check({tag, "_beats"}, beats_seen - s_beats, v.exp_beats);
    check({tag, "_ok_pulses"}, ok_seen - s_ok, {31'h0, v.exp_ok});
    check({tag, "_err_pulses"}, err_seen - s_err, {31'h0, v.exp_err});
  endtask

  initial begin
    int s_beats, s_ok, s_err;
    //           len flip  er extra bad  hold ok err beats
    vecs[0] = '{60,  -1, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64};   // valid minimum frame
    vecs[1] = '{60,  10, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64};   // CRC error
    vecs[2] = '{36,  -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 40};   // short frame
    vecs[3] = '{60,  -1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8};    // overflow
    vecs[4] = '{60,  -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};    // bad preamble
    vecs[5] = '{60,  -1, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64};   // recovery after drop
    vecs[6] = '{60,  -1, 30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64};   // rx_er in data
    vecs[7] = '{60,  -1, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64};   // alignment error
    vecs[8] = '{100, -1, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 104};  // longer valid frame

    rst = 1'b1; crs_dv = 1'b0; rxd = 2'b00; rx_er = 1'b0; tready = 1'b0;
    fork
      forever begin @(negedge clk); monitor_step(); end
      begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", {31'h0, tvalid}, 32'h0);
    check("rst_tdata", {24'h0, tdata}, 32'h0);
    check("rst_tlast_tuser", {30'h0, tlast, tuser}, 32'h0);
    check("rst_pulses", {30'h0, frame_ok, frame_err}, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a frame with data sitting in the FIFO
    tready = 1'b0;
    for (int p = 0; p < 7; p++) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b0);
    @(negedge clk);
    check("midrst_pre_valid", {31'h0, tvalid}, 32'h1);
    s_ok = ok_seen; s_err = err_seen;
    @(posedge clk); #1; rst = 1'b1; crs_dv = 1'b1; rxd = 2'b01;
    @(posedge clk); #1; rst = 1'b0; crs_dv = 1'b0; rxd = 2'b00;
    @(negedge clk);
    check("midrst_tvalid", {31'h0, tvalid}, 32'h0);
    tready = 1'b1;
    s_beats = beats_seen;
    repeat (10) @(posedge clk);
    check("midrst_no_beats", beats_seen - s_beats, 0);
    check("midrst_no_pulses", (ok_seen - s_ok) + (err_seen - s_err), 0);
    run_vec(vecs[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
